button_command_controller: RTL and testbench

//   Sequences the BCD counter from debounced push-button levels.

---
 rtl/button_command_controller_if.sv | 21 ++
 rtl/button_command_controller.sv | 106 ++++++++++
 tb/tb_button_command_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_command_controller_if.sv
// Button levels into the command controller and the one-cycle commands it issues.
// master drives the buttons; slave is the controller itself.
interface button_command_controller_if;
   logic BtnUp;
   logic BtnDown;
   logic BtnClear;
   logic IncPulse;
   logic DecPulse;
   logic ClearPulse;
   logic Busy;

   modport master (
      output BtnUp, BtnDown, BtnClear,
      input  IncPulse, DecPulse, ClearPulse, Busy
   );

   modport slave (
      input  BtnUp, BtnDown, BtnClear,
      output IncPulse, DecPulse, ClearPulse, Busy
   );
endinterface

// File: rtl/button_command_controller.sv
// Turns debounced button levels into one-cycle Inc/Dec/Clear commands for the BCD counter,
// with hold-to-repeat on Up/Down and fixed Clear-first arbitration.
module button_command_controller #(
   parameter int unsigned HoldWidth  = 4,
   parameter int unsigned HoldTime   = 10,
   parameter int unsigned RepeatTime = 4
) (
   input  logic                          Clk,
   input  logic                          Reset,
   button_command_controller_if.slave    bus
);

   localparam logic [1:0] StRelease = 2'd0;
   localparam logic [1:0] StIdle    = 2'd1;
   localparam logic [1:0] StHold    = 2'd2;
   localparam logic [1:0] StRepeat  = 2'd3;

   localparam logic [HoldWidth-1:0] HoldLast   = HoldWidth'(HoldTime - 1);
   localparam logic [HoldWidth-1:0] RepeatLast = HoldWidth'(RepeatTime - 1);

   logic [1:0]           stateQ, stateD;
   logic [HoldWidth-1:0] timerQ, timerD;
   logic                 dirUpQ, dirUpD;
   logic                 incQ, incD;
   logic                 decQ, decD;
   logic                 clearQ, clearD;
   logic                 latched, opposite;
   logic [HoldWidth-1:0] lastCount;

   assign latched   = dirUpQ ? bus.BtnUp   : bus.BtnDown;
   assign opposite  = dirUpQ ? bus.BtnDown : bus.BtnUp;
   assign lastCount = (stateQ == StHold) ? HoldLast : RepeatLast;

   always_comb begin
      stateD = stateQ;
      timerD = timerQ;
      dirUpD = dirUpQ;
      incD   = 1'b0;
      decD   = 1'b0;
      clearD = 1'b0;
      case (stateQ)
         StRelease: begin
            // Wait for a full release so a held button never re-fires.
            if (!(bus.BtnUp || bus.BtnDown || bus.BtnClear)) stateD = StIdle;
         end
         StIdle: begin
            if (bus.BtnClear) begin
               clearD = 1'b1;
               stateD = StRelease;
            end else if (bus.BtnUp ^ bus.BtnDown) begin
               dirUpD = bus.BtnUp;
               incD   = bus.BtnUp;
               decD   = bus.BtnDown;
               timerD = '0;
               stateD = StHold;
            end else if (bus.BtnUp && bus.BtnDown) begin
               stateD = StRelease;
            end
         end
         default: begin
            if (bus.BtnClear) begin
               clearD = 1'b1;
               timerD = '0;
               stateD = StRelease;
            end else if (opposite) begin
               timerD = '0;
               stateD = StRelease;
            end else if (!latched) begin
               timerD = '0;
               stateD = StIdle;
            end else if (timerQ == lastCount) begin
               incD   = dirUpQ;
               decD   = !dirUpQ;
               timerD = '0;
               stateD = StRepeat;
            end else begin
               timerD = timerQ + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ <= StRelease;
         timerQ <= '0;
         dirUpQ <= 1'b0;
         incQ   <= 1'b0;
         decQ   <= 1'b0;
         clearQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         timerQ <= timerD;
         dirUpQ <= dirUpD;
         incQ   <= incD;
         decQ   <= decD;
         clearQ <= clearD;
      end
   end

   assign bus.IncPulse   = incQ;
   assign bus.DecPulse   = decQ;
   assign bus.ClearPulse = clearQ;
   assign bus.Busy       = (stateQ != StIdle);

endmodule

// File: tb/tb_button_command_controller.sv
// Bench for button_command_controller: directed scenarios with literal expectations plus
// randomized button traffic checked every cycle against a behavioural model.
module tb_button_command_controller;

   localparam int unsigned HoldWidth  = 2;
   localparam int unsigned HoldTime   = 3;
   localparam int unsigned RepeatTime = 2;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   button_command_controller_if bus ();

   button_command_controller #(
      .HoldWidth  (HoldWidth),
      .HoldTime   (HoldTime),
      .RepeatTime (RepeatTime)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Model: 0 = waiting for full release, 1 = idle, 2 = a direction is held.
   int         mMode = 0;
   bit         mDirUp = 1'b0;
   int         mElapsed = 0;
   logic [2:0] mPulse = 3'b000;  // {inc, dec, clear}

   always @(posedge Clk or posedge Reset) begin
      bit up, down, clr, held, opp;
      if (Reset) begin
         mMode  = 0;
         mPulse = 3'b000;
      end else begin
         up = bus.BtnUp; down = bus.BtnDown; clr = bus.BtnClear;
         mPulse = 3'b000;
         if (mMode == 0) begin
            if (!(up || down || clr)) mMode = 1;
         end else if (mMode == 1) begin
            if (clr) begin
               mPulse = 3'b001; mMode = 0;
            end else if (up != down) begin
               mDirUp = up; mPulse = up ? 3'b100 : 3'b010; mElapsed = 0; mMode = 2;
            end else if (up && down) begin
               mMode = 0;
            end
         end else begin
            held = mDirUp ? up : down;
            opp  = mDirUp ? down : up;
            if (clr) begin
               mPulse = 3'b001; mMode = 0;
            end else if (opp) begin
               mMode = 0;
            end else if (!held) begin
               mMode = 1;
            end else begin
               mElapsed++;
               if (mElapsed >= int'(HoldTime) &&
                   (mElapsed - int'(HoldTime)) % int'(RepeatTime) == 0)
                  mPulse = mDirUp ? 3'b100 : 3'b010;
            end
         end
      end
   end

   always @(negedge Clk) begin
      logic [3:0] act, exp;
      act = {bus.IncPulse, bus.DecPulse, bus.ClearPulse, bus.Busy};
      exp = {mPulse, (mMode != 1)};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL model_cycle t=%0t {inc,dec,clr,busy} actual=%b required=%b",
                  $time, act, exp);
      end
   end

   task automatic check(input string name, input int actual, input int required);
      tests++;
      if (actual !== required) begin
         fails++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, required);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic setBtn(input bit up, input bit down, input bit clr);
      bus.BtnUp = up; bus.BtnDown = down; bus.BtnClear = clr;
   endtask

   task automatic releaseAll();
      setBtn(0, 0, 0);
      step();
      step();
   endtask

   initial begin
      int pattern;
      int count;
      setBtn(0, 0, 0);
      #1 Reset = 1'b1;
      #20 Reset = 1'b0;
      check("reset_inc", bus.IncPulse, 0);
      check("reset_clear", bus.ClearPulse, 0);
      check("reset_busy", bus.Busy, 1);
      step();
      check("release_to_idle", bus.Busy, 0);

      // Single-cycle press
      setBtn(1, 0, 0);
      step();
      check("tap_inc", bus.IncPulse, 1);
      check("tap_dec", bus.DecPulse, 0);
      setBtn(0, 0, 0);
      step();
      check("tap_inc_gone", bus.IncPulse, 0);
      check("tap_busy_idle", bus.Busy, 0);

      // Hold Up for 10 sampled edges: pulses at offsets 0,3,5,7,9
      releaseAll();
      setBtn(1, 0, 0);
      pattern = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.IncPulse) pattern |= (1 << i);
         if (i == 9) setBtn(0, 0, 0);
      end
      check("hold_repeat_pattern", pattern, 32'h2A9);

      // Up & Down together: conflict, no command
      releaseAll();
      setBtn(1, 1, 0);
      count = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         count += bus.IncPulse + bus.DecPulse + bus.ClearPulse;
      end
      check("conflict_no_pulse", count, 0);
      check("conflict_busy", bus.Busy, 1);
      setBtn(0, 0, 0);
      step();
      check("conflict_release_idle", bus.Busy, 0);

      // Down held, Clear joins two edges later
      releaseAll();
      setBtn(0, 1, 0);
      step();
      check("down_dec", bus.DecPulse, 1);
      step();
      setBtn(0, 1, 1);
      step();
      check("down_then_clear", bus.ClearPulse, 1);
      check("down_then_clear_dec", bus.DecPulse, 0);
      count = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         count += bus.IncPulse + bus.DecPulse + bus.ClearPulse;
      end
      check("after_clear_silent", count, 0);

      // Button held across reset deassertion
      releaseAll();
      setBtn(1, 0, 0);
      #1 Reset = 1'b1;
      step();
      #2 Reset = 1'b0;
      count = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         count += bus.IncPulse;
      end
      check("held_through_reset", count, 0);
      setBtn(0, 0, 0);
      step();
      setBtn(1, 0, 0);
      step();
      check("repress_after_reset", bus.IncPulse, 1);

      // Reset while repeating
      releaseAll();
      setBtn(1, 0, 0);
      for (int i = 0; i < 6; i++) step();
      check("repeat_pulse_before_reset", bus.IncPulse, 1);
      #1 Reset = 1'b1;
      #1;
      check("reset_kills_pulse", bus.IncPulse, 0);
      check("reset_busy_mid", bus.Busy, 1);
      #1 Reset = 1'b0;
      count = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         count += bus.IncPulse;
      end
      check("no_pulse_after_mid_reset", count, 0);
      setBtn(0, 0, 0);
      step();
      setBtn(1, 0, 0);
      step();
      check("repress_after_mid_reset", bus.IncPulse, 1);

      // Random traffic; the per-cycle compare checks it
      releaseAll();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) bus.BtnUp = ~bus.BtnUp;
         if ($urandom_range(0, 7) == 0) bus.BtnDown = ~bus.BtnDown;
         if ($urandom_range(0, 19) == 0) bus.BtnClear = ~bus.BtnClear;
         if ($urandom_range(0, 199) == 0) begin
            #1 Reset = 1'b1;
            #1 Reset = 1'b0;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
